// File: rtl/axis_pkt_fifo.sv
// ---------------------------------------------------------------------------
// axis_pkt_fifo
//   AXI-Stream FIFO with first-word fall-through output. In stream mode it
//   releases beats as soon as they are stored. In packet mode it holds a
//   packet back until its tlast beat is stored. A packet larger than the FIFO
//   is released once the FIFO fills, and then streams through to its tlast.
//   Also reports fill level, stored packet count and almost-full.
//
// Ports
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset (control state only)
//   s_axis_*       : ingress stream (tvalid/tready/tdata/tlast)
//   m_axis_*       : egress stream; tdata/tlast read as 0 while tvalid=0
//   level          : stored beats, 0..DEPTH
//   pkt_cnt        : stored beats carrying tlast
//   almost_full    : registered, level >= AFULL_THRESH
// ---------------------------------------------------------------------------
module axis_pkt_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 16,
  parameter int PKT_MODE     = 0,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic [$clog2(DEPTH):0]  level,
  output logic [$clog2(DEPTH):0]  pkt_cnt,
  output logic                    almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  // Each entry holds {tlast, tdata}. Contents are never reset; validity is
  // tracked by the pointers alone.
  logic [DATA_WIDTH:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] level_q, level_d;
  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          draining_q, draining_d;
  logic          almost_full_q, almost_full_d;

  logic                empty;
  logic                full;
  logic                release_ok;
  logic                wr_en;
  logic                rd_en;
  logic                wr_last;
  logic                rd_last;
  logic [DATA_WIDTH:0] head;

  // The pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign s_axis_tready = !full && !rst;

  // In packet mode, output is held back until a whole packet is stored. A full
  // FIFO is released anyway, and draining keeps that oversize packet flowing
  // until its tlast beat leaves.
  assign release_ok    = (PKT_MODE == 0) || (pkt_cnt_q != '0) || full || draining_q;
  assign m_axis_tvalid = !empty && release_ok;

  assign head         = mem_q[rd_ptr_q[AW-1:0]];
  assign m_axis_tdata = m_axis_tvalid ? head[DATA_WIDTH-1:0] : '0;
  assign m_axis_tlast = m_axis_tvalid && head[DATA_WIDTH];

  assign wr_en   = s_axis_tvalid && s_axis_tready;
  assign rd_en   = m_axis_tvalid && m_axis_tready;
  assign wr_last = wr_en && s_axis_tlast;
  assign rd_last = rd_en && head[DATA_WIDTH];

  assign level       = level_q;
  assign pkt_cnt     = pkt_cnt_q;
  assign almost_full = almost_full_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    pkt_cnt_d  = pkt_cnt_q;
    draining_d = draining_q;

    // DEPTH is a power of two, so the plain increment wraps the index and
    // toggles the wrap bit.
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);

    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + PW'(1);
      2'b01:   level_d = level_q - PW'(1);
      default: level_d = level_q;
    endcase

    case ({wr_last, rd_last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + PW'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - PW'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase

    // A read with no complete packet stored can only be a forced release of
    // an oversize packet. Stay in that state until its tlast beat is read.
    if (rd_en) begin
      if (head[DATA_WIDTH]) begin
        draining_d = 1'b0;
      end else if (pkt_cnt_q == '0) begin
        draining_d = 1'b1;
      end
    end

    almost_full_d = (level_d >= AFULL_LVL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      pkt_cnt_q     <= '0;
      draining_q    <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      pkt_cnt_q     <= pkt_cnt_d;
      draining_q    <= draining_d;
      almost_full_q <= almost_full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end
  end

endmodule
